// File: rtl/awb_gain_apply_if.sv
// Pixel stream bundle (valid / frame-start / packed RGB data) for the AWB path.
interface awb_gain_apply_if #(
  parameter int unsigned DATA_WIDTH = 96
);
  logic                  valid;
  logic                  tuser;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, tuser, data);
  modport slave  (input  valid, tuser, data);
endinterface

// File: rtl/awb_gain_apply.sv
// AWB per-channel gain stage: 3-cycle pipeline applying Q4.8 R/G/B gains with
// round-half-up and saturation; gains/bypass switch only on frame start.
module awb_gain_apply #(
  parameter int unsigned PIX_PER_CLK = 4,
  parameter int unsigned DATA_WIDTH  = 96,
  parameter int unsigned GAIN_WIDTH  = 12,
  parameter int unsigned GAIN_FRAC   = 8
) (
  input  logic                  I_clk,
  input  logic                  I_rst_n,
  awb_gain_apply_if.slave       I_pix,
  awb_gain_apply_if.master      O_pix,
  input  logic                  I_gain_valid,
  input  logic [GAIN_WIDTH-1:0] I_gain_r,
  input  logic [GAIN_WIDTH-1:0] I_gain_g,
  input  logic [GAIN_WIDTH-1:0] I_gain_b,
  input  logic                  I_bypass,
  output logic                  O_gain_busy,
  output logic                  O_gain_upd
);

  localparam int unsigned LANES  = PIX_PER_CLK * 3;
  localparam int unsigned PROD_W = 8 + GAIN_WIDTH;
  localparam int unsigned Q_W    = PROD_W + 1 - GAIN_FRAC;
  localparam logic [GAIN_WIDTH-1:0] UNITY = GAIN_WIDTH'(2 ** GAIN_FRAC);
  localparam logic [PROD_W:0]       RND   = (PROD_W + 1)'(2 ** (GAIN_FRAC - 1));

  // Channel order within a pixel: index 0 = B, 1 = G, 2 = R (matches bit packing).
  logic [2:0][GAIN_WIDTH-1:0] gain_in_c;

  logic [2:0][GAIN_WIDTH-1:0] pend_q, pend_d, act_q, act_d, s1_gain_q, s1_gain_d;
  logic                       pend_flag_q, pend_flag_d;
  logic                       byp_q, byp_d;
  logic                       upd_q, upd_d;

  logic                       s1_valid_q, s1_valid_d, s1_tuser_q, s1_tuser_d;
  logic [DATA_WIDTH-1:0]      s1_data_q, s1_data_d;
  logic                       s2_valid_q, s2_valid_d, s2_tuser_q, s2_tuser_d;
  logic [LANES-1:0][PROD_W-1:0] s2_prod_q, s2_prod_d;
  logic                       out_valid_q, out_valid_d, out_tuser_q, out_tuser_d;
  logic [DATA_WIDTH-1:0]      out_data_q, out_data_d;

  logic [LANES-1:0][PROD_W:0] rnd_c;
  logic [LANES-1:0][Q_W-1:0]  q_c;

  assign gain_in_c = {I_gain_r, I_gain_g, I_gain_b};

  always_comb begin
    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    act_d       = act_q;
    byp_d       = byp_q;
    upd_d       = 1'b0;
    out_data_d  = '0;

    // Gain bookkeeping: a coincident gain pulse at frame start goes straight to active.
    if (I_pix.tuser) begin
      byp_d       = I_bypass;
      pend_flag_d = 1'b0;
      if (I_gain_valid) begin
        act_d = gain_in_c;
        upd_d = 1'b1;
      end else if (pend_flag_q) begin
        act_d = pend_q;
        upd_d = 1'b1;
      end
    end else if (I_gain_valid) begin
      pend_d      = gain_in_c;
      pend_flag_d = 1'b1;
    end

    // S1 takes next-active settings so the frame-start beat already sees them;
    // bypass is realised as unity gain, which rounds back to the input exactly.
    s1_valid_d = I_pix.valid;
    s1_tuser_d = I_pix.tuser;
    s1_data_d  = I_pix.data;
    for (int unsigned c = 0; c < 3; c++) begin
      s1_gain_d[c] = byp_d ? UNITY : act_d[c];
    end

    s2_valid_d = s1_valid_q;
    s2_tuser_d = s1_tuser_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      s2_prod_d[i] = PROD_W'(s1_data_q[8*i +: 8]) * PROD_W'(s1_gain_q[i % 3]);
    end

    out_valid_d = s2_valid_q;
    out_tuser_d = s2_tuser_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      rnd_c[i] = (PROD_W + 1)'(s2_prod_q[i]) + RND;
      q_c[i]   = Q_W'(rnd_c[i] >> GAIN_FRAC);
      out_data_d[8*i +: 8] = (q_c[i] > Q_W'(255)) ? 8'hFF : q_c[i][7:0];
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      pend_q      <= {3{UNITY}};
      pend_flag_q <= 1'b0;
      act_q       <= {3{UNITY}};
      byp_q       <= 1'b0;
      upd_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_tuser_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_gain_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_tuser_q  <= 1'b0;
      s2_prod_q   <= '0;
      out_valid_q <= 1'b0;
      out_tuser_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      pend_q      <= pend_d;
      pend_flag_q <= pend_flag_d;
      act_q       <= act_d;
      byp_q       <= byp_d;
      upd_q       <= upd_d;
      s1_valid_q  <= s1_valid_d;
      s1_tuser_q  <= s1_tuser_d;
      s1_data_q   <= s1_data_d;
      s1_gain_q   <= s1_gain_d;
      s2_valid_q  <= s2_valid_d;
      s2_tuser_q  <= s2_tuser_d;
      s2_prod_q   <= s2_prod_d;
      out_valid_q <= out_valid_d;
      out_tuser_q <= out_tuser_d;
      out_data_q  <= out_data_d;
    end
  end

  assign O_pix.valid = out_valid_q;
  assign O_pix.tuser = out_tuser_q;
  assign O_pix.data  = out_data_q;
  assign O_gain_busy = pend_flag_q;
  assign O_gain_upd  = upd_q;

endmodule

// File: tb/tb_awb_gain_apply.sv
// Directed bench for awb_gain_apply: latency, gain scheduling, rounding,
// saturation, bypass and asynchronous reset, with hand-computed expectations.
module tb_awb_gain_apply;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gv, byp;
  logic [11:0] gr, gg, gb;
  logic        busy, upd;
  int          n_chk = 0;
  int          n_err = 0;

  awb_gain_apply_if #(.DATA_WIDTH(96)) in_if ();
  awb_gain_apply_if #(.DATA_WIDTH(96)) out_if ();

  awb_gain_apply dut (
    .I_clk        (clk),
    .I_rst_n      (rst_n),
    .I_pix        (in_if),
    .O_pix        (out_if),
    .I_gain_valid (gv),
    .I_gain_r     (gr),
    .I_gain_g     (gg),
    .I_gain_b     (gb),
    .I_bypass     (byp),
    .O_gain_busy  (busy),
    .O_gain_upd   (upd)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] mk(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    return {4{r, g, b}};
  endfunction

  task automatic gain(input logic [11:0] r, input logic [11:0] g, input logic [11:0] b);
    gr = r; gg = g; gb = b; gv = 1'b1;
    step();
    gv = 1'b0;
  endtask

  // One isolated beat; checks update pulse, 3-cycle latency and single-cycle valid.
  task automatic push(input logic tu, input logic by, input logic g,
                      input logic [95:0] din, input logic [95:0] dexp,
                      input logic eupd, input string tag);
    in_if.valid = 1'b1; in_if.tuser = tu; in_if.data = din; byp = by; gv = g;
    step();
    in_if.valid = 1'b0; in_if.tuser = 1'b0; byp = 1'b0; gv = 1'b0;
    check({tag, "/upd"}, 96'(upd), 96'(eupd));
    step();
    check({tag, "/early_valid"}, 96'(out_if.valid), 96'd0);
    check({tag, "/upd_clear"}, 96'(upd), 96'd0);
    step();
    check({tag, "/valid"}, 96'(out_if.valid), 96'd1);
    check({tag, "/tuser"}, 96'(out_if.tuser), 96'(tu));
    check({tag, "/data"}, out_if.data, dexp);
    step();
    check({tag, "/valid_end"}, 96'(out_if.valid), 96'd0);
  endtask

  initial begin
    rst_n = 1'b0; gv = 1'b0; byp = 1'b0;
    gr = 12'd0; gg = 12'd0; gb = 12'd0;
    in_if.valid = 1'b0; in_if.tuser = 1'b0; in_if.data = '0;
    step(); step();
    check("rst/valid", 96'(out_if.valid), 96'd0);
    check("rst/tuser", 96'(out_if.tuser), 96'd0);
    check("rst/data",  out_if.data, 96'd0);
    check("rst/busy",  96'(busy), 96'd0);
    check("rst/upd",   96'(upd), 96'd0);
    #2 rst_n = 1'b1;
    step();

    // Default unity gains
    push(1, 0, 0, mk(200, 100, 50), mk(200, 100, 50), 0, "unity");

    // Scheduled gain set, applied at frame start
    gain(12'd512, 12'd256, 12'd128);
    check("sched/busy_set", 96'(busy), 96'd1);
    push(1, 0, 0, mk(100, 100, 101), mk(200, 100, 51), 1, "sched_f0");
    check("sched/busy_clr", 96'(busy), 96'd0);
    push(0, 0, 0, mk(100, 100, 101), mk(200, 100, 51), 0, "sched_f1");

    // Saturation, zero gain and rounding across distinct pixels
    gain(12'd4095, 12'd0, 12'd300);
    push(1, 0, 0, 96'h10FF01_000000_01C8C8_FF4DFF,
                  96'hFF0001_000000_1000EA_FF00FF, 1, "sat");

    // Mid-frame pulses are deferred; last pulse wins
    gain(12'd256, 12'd256, 12'd256);
    push(1, 0, 0, mk(10, 20, 30), mk(10, 20, 30), 1, "mid_f0");
    gain(12'd768, 12'd256, 12'd256);
    gain(12'd512, 12'd256, 12'd256);
    check("mid/busy", 96'(busy), 96'd1);
    push(0, 0, 0, mk(10, 20, 30), mk(10, 20, 30), 0, "mid_old");
    push(1, 0, 0, mk(10, 20, 30), mk(20, 20, 30), 1, "mid_new");
    push(0, 0, 0, mk(10, 20, 30), mk(20, 20, 30), 0, "mid_new1");

    // Gain pulse coincident with frame start
    gr = 12'd256; gg = 12'd384; gb = 12'd256;
    push(1, 0, 1, mk(10, 20, 30), mk(10, 30, 30), 1, "coinc");
    check("coinc/busy", 96'(busy), 96'd0);

    // Bypass sampled only at frame start
    gain(12'd512, 12'd512, 12'd512);
    push(1, 1, 0, mk(100, 200, 255), mk(100, 200, 255), 1, "byp_f0");
    push(0, 0, 0, mk(100, 200, 255), mk(100, 200, 255), 0, "byp_f1");
    push(1, 0, 0, mk(100, 200, 255), mk(200, 255, 255), 0, "byp_off");

    // Back-to-back frame starts at full rate
    in_if.valid = 1'b1; in_if.tuser = 1'b1; byp = 1'b1; in_if.data = mk(100, 200, 255);
    step();
    byp = 1'b0;
    step();
    in_if.tuser = 1'b0; in_if.data = mk(50, 50, 50);
    step();
    in_if.valid = 1'b0;
    check("b2b/d0",  out_if.data, mk(100, 200, 255));
    check("b2b/t0",  96'(out_if.tuser), 96'd1);
    step();
    check("b2b/d1",  out_if.data, mk(200, 255, 255));
    check("b2b/t1",  96'(out_if.tuser), 96'd1);
    step();
    check("b2b/d2",  out_if.data, mk(100, 100, 100));
    check("b2b/t2",  96'(out_if.tuser), 96'd0);
    check("b2b/v2",  96'(out_if.valid), 96'd1);
    step();
    check("b2b/vend", 96'(out_if.valid), 96'd0);

    // Asynchronous reset mid-frame with a pending gain set
    gain(12'd300, 12'd300, 12'd300);
    in_if.valid = 1'b1; in_if.data = mk(40, 40, 40);
    step();
    in_if.valid = 1'b0;
    step(); step();
    check("arst/pre_valid", 96'(out_if.valid), 96'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst/valid", 96'(out_if.valid), 96'd0);
    check("arst/data",  out_if.data, 96'd0);
    check("arst/busy",  96'(busy), 96'd0);
    #1 rst_n = 1'b1;
    step();
    push(1, 0, 0, mk(200, 100, 50), mk(200, 100, 50), 0, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
